// File: rtl/sseg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_pkg
//  Description : Shared constants for the six-digit 7-segment scan driver.
//  Revision    : 1.0  initial release
// ============================================================================
package sseg_pkg;

  localparam int NDIG = 6;

  // Active-low {g,f,e,d,c,b,a} patterns for common-anode digits.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] DIG_BLANK = 4'd10;
  localparam logic [3:0] DIG_RESET = 4'd8;
  localparam logic [5:0] AN_OFF    = 6'h3F;

  typedef logic [3:0] digit_t;

endpackage : sseg_pkg
`default_nettype wire

// File: rtl/sseg_decode.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_decode
//  Description : Combinational digit code to active-low segment pattern.
//  Revision    : 1.0  initial release
// ============================================================================
module sseg_decode
  import sseg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule : sseg_decode
`default_nettype wire

// File: rtl/sseg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_scan_driver
//  Description : Six-digit time-multiplexed common-anode 7-segment driver with
//                per-frame shadow capture and anti-ghost dead time.
//  Revision    : 1.0  initial release
// ============================================================================
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int DEAD     = 16
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] d4,
  input  logic [3:0] d5,
  input  logic [5:0] dp_mask,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic       frame
);

  localparam int             CW       = $clog2(PRESCALE);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0]  DEAD_CNT = CW'(DEAD);
  localparam logic [2:0]     IDX_MAX  = 3'(NDIG - 1);

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  digit_t        r_shadow [NDIG];
  logic [5:0]    r_shadow_dp;
  logic          r_frame;
  logic [5:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    w_idx_nxt;
  logic          w_wrap;
  logic          w_capture;
  logic          w_lit;
  digit_t        w_code;
  logic          w_dp_bit;
  logic [6:0]    w_dec;

  assign w_wrap    = (r_cnt == CNT_MAX);
  assign w_capture = en && w_wrap && (r_idx == IDX_MAX);

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_idx_nxt = r_idx;
    if (en) begin
      if (w_wrap) begin
        w_cnt_nxt = '0;
        w_idx_nxt = (r_idx == IDX_MAX) ? 3'd0 : r_idx + 3'd1;
      end else begin
        w_cnt_nxt = r_cnt + CW'(1);
      end
    end
  end

  // Outputs follow the post-update slot; on a capture edge the new frame
  // starts at slot 0, so its contents come straight from the inputs.
  always_comb begin
    w_code   = r_shadow[w_idx_nxt];
    w_dp_bit = r_shadow_dp[w_idx_nxt];
    if (w_capture) begin
      w_code   = d0;
      w_dp_bit = dp_mask[0];
    end
  end

  assign w_lit = en && (w_cnt_nxt >= DEAD_CNT);

  sseg_decode u_decode (
    .code (w_code),
    .seg  (w_dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shadow_dp <= '0;
      r_frame     <= 1'b0;
      for (int i = 0; i < NDIG; i++) begin
        r_shadow[i] <= DIG_RESET;
      end
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_frame <= w_capture;
      if (w_capture) begin
        r_shadow[0] <= d0;
        r_shadow[1] <= d1;
        r_shadow[2] <= d2;
        r_shadow[3] <= d3;
        r_shadow[4] <= d4;
        r_shadow[5] <= d5;
        r_shadow_dp <= dp_mask;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_lit ? ~(6'b1 << w_idx_nxt) : AN_OFF;
      r_seg <= w_lit ? w_dec : SEG_BLANK;
      r_dp  <= w_lit ? ~w_dp_bit : 1'b1;
    end
  end

  assign seg   = r_seg;
  assign dp    = r_dp;
  assign an    = r_an;
  assign frame = r_frame;

endmodule : sseg_scan_driver
`default_nettype wire

// File: tb/tb_sseg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sseg_scan_driver
//  Description : Self-checking bench for sseg_scan_driver (PRESCALE=4, DEAD=1).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sseg_scan_driver;

  localparam int P     = 4;
  localparam int DEAD  = 1;
  localparam int FRAME = 6 * P;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] d0, d1, d2, d3, d4, d5;
  logic [5:0] dp_mask;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       frame;

  always #5 clk = ~clk;

  sseg_scan_driver #(.PRESCALE(P), .DEAD(DEAD)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .d0      (d0),
    .d1      (d1),
    .d2      (d2),
    .d3      (d3),
    .d4      (d4),
    .d5      (d5),
    .dp_mask (dp_mask),
    .seg     (seg),
    .dp      (dp),
    .an      (an),
    .frame   (frame)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] c);
    case (c)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Reference model: position in the frame as a plain count of enabled cycles.
  int         m_t;
  logic       m_en;
  logic       m_frame;
  logic [3:0] m_sd [6];
  logic [5:0] m_sdp;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_t     <= 0;
      m_en    <= 1'b0;
      m_frame <= 1'b0;
      m_sdp   <= '0;
      for (int i = 0; i < 6; i++) m_sd[i] <= 4'd8;
    end else begin
      m_en    <= en;
      m_frame <= 1'b0;
      if (en) begin
        m_t <= (m_t + 1) % FRAME;
        if ((m_t + 1) % FRAME == 0) begin
          m_frame <= 1'b1;
          m_sdp   <= dp_mask;
          m_sd[0] <= d0; m_sd[1] <= d1; m_sd[2] <= d2;
          m_sd[3] <= d3; m_sd[4] <= d4; m_sd[5] <= d5;
        end
      end
    end
  end

  bit mon_on = 1'b0;

  always @(negedge clk) begin
    if (mon_on) begin
      int   slot;
      logic lit;
      slot = m_t / P;
      lit  = m_en && ((m_t % P) >= DEAD);
      check("mon_an",    {26'd0, an},  lit ? {26'd0, ~(6'b1 << slot)} : 32'h3F);
      check("mon_seg",   {25'd0, seg}, lit ? {25'd0, seg_of(m_sd[slot])} : 32'h7F);
      check("mon_dp",    {31'd0, dp},  lit ? {31'd0, ~m_sdp[slot]} : 32'h1);
      check("mon_frame", {31'd0, frame}, {31'd0, m_frame});
    end
  end

  typedef struct {
    int         slot;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } vec_t;

  vec_t       vt [6];
  logic [5:0] an_tab [6];
  int         k = 0;

  task automatic go_to(input int target);
    while (k < target) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    int nf;
    int last;
    logic prev_f;

    an_tab[0] = 6'h3E; an_tab[1] = 6'h3D; an_tab[2] = 6'h3B;
    an_tab[3] = 6'h37; an_tab[4] = 6'h2F; an_tab[5] = 6'h1F;
    vt[0] = '{0, 6'h3E, 7'h79, 1'b1};
    vt[1] = '{1, 6'h3D, 7'h30, 1'b1};
    vt[2] = '{2, 6'h3B, 7'h19, 1'b1};
    vt[3] = '{3, 6'h37, 7'h10, 1'b1};
    vt[4] = '{4, 6'h2F, 7'h19, 1'b1};
    vt[5] = '{5, 6'h1F, 7'h7F, 1'b1};

    reset = 1'b1; en = 1'b0; dp_mask = '0;
    d0 = 0; d1 = 0; d2 = 0; d3 = 0; d4 = 0; d5 = 0;
    #3;
    check("rst_an", {26'd0, an}, 32'h3F);
    check("rst_seg", {25'd0, seg}, 32'h7F);
    check("rst_dp", {31'd0, dp}, 32'h1);
    check("rst_frame", {31'd0, frame}, 32'h0);

    @(negedge clk); @(negedge clk);
    reset = 1'b0; en = 1'b1;
    d0 = 1; d1 = 3; d2 = 4; d3 = 9; d4 = 4; d5 = 10;
    mon_on = 1'b1;

    // First frame after reset: 888888 regardless of inputs
    for (int j = 1; j <= FRAME; j++) begin
      go_to(j);
      check("t1_an", {26'd0, an}, (j % P == 0) ? 32'h3F : {26'd0, an_tab[j / P]});
      if (j % P != 0) check("t1_seg", {25'd0, seg}, 32'h00);
      check("t1_frame", {31'd0, frame}, (j == FRAME) ? 32'h1 : 32'h0);
    end

    for (int i = 0; i < 6; i++) begin
      go_to(FRAME + P * vt[i].slot + 2);
      check("t2_an", {26'd0, an}, {26'd0, vt[i].an});
      check("t2_seg", {25'd0, seg}, {25'd0, vt[i].seg});
      check("t2_dp", {31'd0, dp}, {31'd0, vt[i].dp});
    end

    d2 = 7;
    go_to(48);
    check("t3_frame", {31'd0, frame}, 32'h1);
    go_to(53);
    d2 = 5; dp_mask = 6'b000100;
    go_to(58);
    check("t3_an_old", {26'd0, an}, 32'h3B);
    check("t3_seg_old", {25'd0, seg}, 32'h78);
    check("t3_dp_old", {31'd0, dp}, 32'h1);
    go_to(82);
    check("t3_an_new", {26'd0, an}, 32'h3B);
    check("t3_seg_new", {25'd0, seg}, 32'h12);
    check("t3_dp_new", {31'd0, dp}, 32'h0);

    nf = 0; last = -1; prev_f = frame;
    for (int j = 0; j < 240; j++) begin
      go_to(k + 1);
      if (frame) begin
        check("t4_width", {31'd0, prev_f}, 32'h0);
        if (last >= 0) check("t4_gap", k - last, FRAME);
        nf++;
        last = k;
      end
      prev_f = frame;
    end
    check("t4_count", nf, 10);

    go_to(346);
    check("t5_pre_an", {26'd0, an}, 32'h3B);
    en = 1'b0;
    for (int j = 0; j < 10; j++) begin
      go_to(k + 1);
      check("t5_off_an", {26'd0, an}, 32'h3F);
      check("t5_off_frame", {31'd0, frame}, 32'h0);
    end
    en = 1'b1;
    go_to(k + 1);
    check("t5_resume_an", {26'd0, an}, 32'h3B);
    go_to(k + 1);
    check("t5_dead_an", {26'd0, an}, 32'h3F);
    go_to(k + 1);
    check("t5_next_an", {26'd0, an}, 32'h37);
    go_to(k + 1);

    #2;
    reset = 1'b1;
    #1;
    check("t6_an", {26'd0, an}, 32'h3F);
    check("t6_seg", {25'd0, seg}, 32'h7F);
    check("t6_dp", {31'd0, dp}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    for (int j = 1; j <= FRAME; j++) begin
      @(negedge clk);
      check("t6_an_scan", {26'd0, an}, (j % P == 0) ? 32'h3F : {26'd0, an_tab[j / P]});
      if (j % P != 0) check("t6_seg8", {25'd0, seg}, 32'h00);
    end

    // Randomized run against the reference model
    for (int j = 0; j < 3000; j++) begin
      @(negedge clk);
      en      = ($urandom_range(0, 9) != 0);
      reset   = ($urandom_range(0, 599) == 0);
      d0 = 4'($urandom); d1 = 4'($urandom); d2 = 4'($urandom);
      d3 = 4'($urandom); d4 = 4'($urandom); d5 = 4'($urandom);
      dp_mask = 6'($urandom);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mon_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_sseg_scan_driver
`default_nettype wire
